// File: rtl/muntjac_fpu_round_pipe_pkg.sv
// Shared FPU types: RISC-V rounding modes, fflags layout and the result class
// that is carried down the rounding pipeline.
package muntjac_fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rounding_mode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } class_e;

endpackage

// File: rtl/muntjac_fpu_round_pipe_if.sv
// Handshake and data bundle between the FMA datapath, the rounder and its consumer.
interface muntjac_fpu_round_pipe_if #(
    parameter int unsigned ExpWidth   = 8,
    parameter int unsigned FracWidth  = 23,
    parameter int unsigned InExpWidth = 10,
    parameter int unsigned InSigWidth = 26
) ();
    import muntjac_fpu_pkg::*;

    logic                              flush_i;
    logic                              in_valid_i;
    logic                              in_ready_o;
    rounding_mode_e                    rounding_mode_i;
    logic                              invalid_i;
    logic                              sign_i;
    logic signed [InExpWidth-1:0]      exponent_i;
    logic [InSigWidth-1:0]             significand_i;
    logic                              is_zero_i;
    logic                              is_inf_i;
    logic                              is_nan_i;
    logic                              out_valid_o;
    logic                              out_ready_i;
    logic [ExpWidth+FracWidth:0]       result_o;
    fflags_t                           fflags_o;

    modport master (
        output flush_i, in_valid_i, rounding_mode_i, invalid_i, sign_i, exponent_i,
               significand_i, is_zero_i, is_inf_i, is_nan_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, fflags_o
    );

    modport slave (
        input  flush_i, in_valid_i, rounding_mode_i, invalid_i, sign_i, exponent_i,
               significand_i, is_zero_i, is_inf_i, is_nan_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, fflags_o
    );

endinterface

// File: rtl/muntjac_fpu_round_pipe_decide.sv
// Round-increment decision from mode, sign and the lsb/round/sticky bits.
module muntjac_fpu_round_decide
    import muntjac_fpu_pkg::*;
(
    input  rounding_mode_e mode,
    input  logic           sign,
    input  logic           lsb,
    input  logic           round,
    input  logic           sticky,
    output logic           inc
);

    always_comb begin
        inc = 1'b0;
        case (mode)
            RTZ:     inc = 1'b0;
            RDN:     inc = (round | sticky) & sign;
            RUP:     inc = (round | sticky) & ~sign;
            RMM:     inc = round;
            default: inc = round & (sticky | lsb);
        endcase
    end

endmodule

// File: rtl/muntjac_fpu_round_pipe.sv
// Two-stage rounder/packer: stage 1 denormalises and decides the increment,
// stage 2 applies it, detects overflow and packs the IEEE result with fflags.
module muntjac_fpu_round_pipe
    import muntjac_fpu_pkg::*;
#(
    parameter int unsigned ExpWidth   = 8,
    parameter int unsigned FracWidth  = 23,
    parameter int unsigned InExpWidth = 10,
    parameter int unsigned InSigWidth = 26
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    muntjac_fpu_round_pipe_if.slave bus
);

    localparam int unsigned GuardWidth = InSigWidth - FracWidth - 1;
    localparam int unsigned ShWidth    = $clog2(InSigWidth + 2);
    localparam int unsigned ResWidth   = 1 + ExpWidth + FracWidth;
    localparam int          Bias       = 2 ** (ExpWidth - 1) - 1;
    localparam int          Emin       = 1 - Bias;

    typedef logic signed [InExpWidth:0] wexp_t;

    // ---------------- stage 1 ----------------
    wexp_t                     exp_w;
    wexp_t                     sh_diff;
    logic                      tiny_pre;
    logic [ShWidth-1:0]        sh;
    logic [2*InSigWidth:0]     wide;
    logic [InSigWidth-1:0]     sig_sh;
    rounding_mode_e            mode;
    class_e                    cls;
    logic                      inc, inc_unb, carry_unb, tiny;

    assign exp_w    = {bus.exponent_i[InExpWidth-1], bus.exponent_i};
    assign tiny_pre = exp_w < wexp_t'(Emin);
    assign sh_diff  = wexp_t'(Emin) - exp_w;

    always_comb begin
        sh = '0;
        if (tiny_pre) begin
            if (sh_diff > wexp_t'(InSigWidth + 1)) sh = ShWidth'(InSigWidth + 1);
            else                                   sh = sh_diff[ShWidth-1:0];
        end
    end

    // Bits shifted out land in the low half and collapse into the sticky bit.
    assign wide   = {bus.significand_i, {(InSigWidth + 1){1'b0}}} >> sh;
    assign sig_sh = {wide[2*InSigWidth:InSigWidth+2], wide[InSigWidth+1] | (|wide[InSigWidth:0])};

    always_comb begin
        mode = RNE;
        case (bus.rounding_mode_i)
            RNE, RTZ, RDN, RUP, RMM: mode = bus.rounding_mode_i;
            default:                 mode = RNE;
        endcase
    end

    always_comb begin
        cls = CLS_NORMAL;
        if (bus.is_nan_i)       cls = CLS_NAN;
        else if (bus.is_inf_i)  cls = CLS_INF;
        else if (bus.is_zero_i) cls = CLS_ZERO;
    end

    muntjac_fpu_round_decide u_decide (
        .mode   (mode),
        .sign   (bus.sign_i),
        .lsb    (sig_sh[GuardWidth]),
        .round  (sig_sh[GuardWidth-1]),
        .sticky (|sig_sh[GuardWidth-2:0]),
        .inc    (inc)
    );

    // Rounding at unbounded exponent: a value just below 2^emin that rounds up to it is not tiny.
    muntjac_fpu_round_decide u_decide_unb (
        .mode   (mode),
        .sign   (bus.sign_i),
        .lsb    (bus.significand_i[GuardWidth]),
        .round  (bus.significand_i[GuardWidth-1]),
        .sticky (|bus.significand_i[GuardWidth-2:0]),
        .inc    (inc_unb)
    );

    assign carry_unb = (&bus.significand_i[InSigWidth-1:GuardWidth]) & inc_unb;
    assign tiny      = tiny_pre & ~((exp_w == wexp_t'(Emin - 1)) & carry_unb);

    logic                  s1_valid, s1_sign, s1_invalid, s1_inc, s1_inexact, s1_tiny;
    class_e                s1_cls;
    rounding_mode_e        s1_mode;
    logic [FracWidth:0]    s1_sig;
    wexp_t                 s1_exp;

    logic s2_valid, s2_adv, in_ready;

    assign s2_adv   = ~s2_valid | bus.out_ready_i;
    assign in_ready = ~s1_valid | s2_adv;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
        end else if (bus.flush_i) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= bus.in_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_ready && bus.in_valid_i) begin
            s1_sign    <= bus.sign_i;
            s1_invalid <= bus.invalid_i;
            s1_cls     <= cls;
            s1_mode    <= mode;
            s1_sig     <= sig_sh[InSigWidth-1:GuardWidth];
            s1_exp     <= tiny_pre ? wexp_t'(Emin) : exp_w;
            s1_inc     <= inc;
            s1_inexact <= |sig_sh[GuardWidth-1:0];
            s1_tiny    <= tiny;
        end
    end

    // ---------------- stage 2 ----------------
    logic [FracWidth+1:0]  sum;
    logic                  carry, int_bit, ovf;
    wexp_t                 bexp;
    logic [ResWidth-1:0]   inf_res, maxf_res, res;
    fflags_t               fl;
    logic [ResWidth-1:0]   s2_result;
    fflags_t               s2_fflags;

    assign sum     = {1'b0, s1_sig} + (FracWidth + 2)'(s1_inc);
    assign carry   = sum[FracWidth+1];
    assign int_bit = carry | sum[FracWidth];
    assign bexp    = int_bit ? (s1_exp + wexp_t'(Bias) + wexp_t'(carry)) : '0;
    assign ovf     = int_bit & (bexp >= wexp_t'(2 ** ExpWidth - 1));

    assign inf_res  = {s1_sign, {ExpWidth{1'b1}}, {FracWidth{1'b0}}};
    assign maxf_res = {s1_sign, {(ExpWidth - 1){1'b1}}, 1'b0, {FracWidth{1'b1}}};

    always_comb begin
        res    = '0;
        fl     = '0;
        fl.nv  = s1_invalid;
        case (s1_cls)
            CLS_NAN:  res = {1'b0, {ExpWidth{1'b1}}, 1'b1, {(FracWidth - 1){1'b0}}};
            CLS_INF:  res = inf_res;
            CLS_ZERO: res = {s1_sign, {(ResWidth - 1){1'b0}}};
            default: begin
                if (ovf) begin
                    fl.of = 1'b1;
                    fl.nx = 1'b1;
                    case (s1_mode)
                        RTZ:     res = maxf_res;
                        RDN:     res = s1_sign ? inf_res : maxf_res;
                        RUP:     res = s1_sign ? maxf_res : inf_res;
                        default: res = inf_res;
                    endcase
                end else begin
                    res   = {s1_sign, bexp[ExpWidth-1:0], sum[FracWidth-1:0]};
                    fl.nx = s1_inexact;
                    fl.uf = s1_tiny & s1_inexact;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_fflags <= '0;
        end else if (bus.flush_i) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= res;
                s2_fflags <= fl;
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = s2_valid;
    assign bus.result_o    = s2_result;
    assign bus.fflags_o    = s2_fflags;

endmodule
